// File: rtl/hazard_unit.sv
// hazard_unit: RV32 5-stage forwarding, load-use/branch stall-flush and memory-wait hold.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_unit #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic [1:0]       ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemAccessM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic {IDLE, MEM_WAIT} state_t;
  state_t        r_state, w_state_nxt;
  logic [WW-1:0] r_wcnt, w_wcnt_nxt;
  logic          r_mem_timeout, w_lw_stall, w_mem_wait, w_hold;

  assign ForwardAE = (RegWriteM && RdM != 5'd0 && RdM == Rs1E) ? 2'b10 :
                     (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ? 2'b01 : 2'b00;
  assign ForwardBE = (RegWriteM && RdM != 5'd0 && RdM == Rs2E) ? 2'b10 :
                     (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ? 2'b01 : 2'b00;
  assign w_lw_stall = (ResultSrcE == 2'b01) && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
  assign w_mem_wait = MemAccessM & ~MemReadyM;

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_hold      = 1'b0;
    if (r_state == IDLE) begin
      w_hold = w_mem_wait;
      if (w_mem_wait) begin
        w_state_nxt = MEM_WAIT;
        w_wcnt_nxt  = WW'(1);
      end
    end else begin
      w_hold = ~MemReadyM;
      if (MemReadyM) begin
        w_state_nxt = IDLE;
        w_wcnt_nxt  = '0;
      end else if (r_wcnt != WW'(MEM_TIMEOUT)) begin
        w_wcnt_nxt = r_wcnt + WW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_wcnt        <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wcnt        <= w_wcnt_nxt;
      r_mem_timeout <= r_mem_timeout | (w_wcnt_nxt == WW'(MEM_TIMEOUT));
    end
  end

  // A held pipe defers load-use and branch decisions to the release cycle.
  assign StallF      = ~reset & (w_hold | w_lw_stall);
  assign StallD      = ~reset & (w_hold | w_lw_stall);
  assign StallE      = ~reset & w_hold;
  assign StallM      = ~reset & w_hold;
  assign FlushW      = ~reset & w_hold;
  assign FlushD      = ~reset & ~w_hold & PCSrcE;
  assign FlushE      = ~reset & ~w_hold & (w_lw_stall | PCSrcE);
  assign mem_timeout = r_mem_timeout;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallF && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (FlushD && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end
  assign stall_cycles = r_stall_cnt;
  assign flush_cycles = r_flush_cnt;
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and randomized checks of hazard_unit against a behavioural model.
module tb_hazard_unit;
  localparam int T = 4;
  logic clk = 0, reset = 1;
  logic [4:0] Rs1D = 0, Rs2D = 0, Rs1E = 0, Rs2E = 0, RdE = 0, RdM = 0, RdW = 0;
  logic [1:0] ResultSrcE = 0;
  logic RegWriteM = 0, RegWriteW = 0, PCSrcE = 0, MemAccessM = 0, MemReadyM = 0;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_timeout;
  logic [1:0] ForwardAE, ForwardBE;
  logic [31:0] stall_cycles, flush_cycles;
  logic [6:0] ctl;
  int n_checks = 0, n_fail = 0;

  localparam logic [6:0] HOLD = 7'b1111001;
  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  hazard_unit #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles),
    .flush_cycles(flush_cycles));

  always #5 clk = ~clk;

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    ResultSrcE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MemAccessM = 0; MemReadyM = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); idle_inputs(); reset = 1;
    @(posedge clk); @(negedge clk); reset = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1; MemAccessM = 1; ResultSrcE = 2'b01; RdE = 3; Rs1D = 3; PCSrcE = 1;
    #1;
    n_checks++; if (ctl !== 7'b0) begin n_fail++; $display("FAIL reset_ctl got %b want 0000000", ctl); end
    @(posedge clk); #1;
    n_checks++; if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", mem_timeout); end
    n_checks++; if (stall_cycles !== 0 || flush_cycles !== 0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cycles, flush_cycles); end
    do_reset();
  endtask

  task automatic test_forwarding();
    @(negedge clk); idle_inputs();
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 5; #1;
    n_checks++; if (ForwardAE !== 2'b10) begin n_fail++; $display("FAIL fwd_m_beats_w got %b want 10", ForwardAE); end
    RdM = 0; #1;
    n_checks++; if (ForwardAE !== 2'b01) begin n_fail++; $display("FAIL fwd_w got %b want 01", ForwardAE); end
    n_checks++; if (ForwardBE !== 2'b01) begin n_fail++; $display("FAIL fwdb_w got %b want 01", ForwardBE); end
    RdW = 0; Rs1E = 0; Rs2E = 0; #1;
    n_checks++; if ({ForwardAE, ForwardBE} !== 4'b0) begin n_fail++; $display("FAIL fwd_x0 got %b%b want 0000", ForwardAE, ForwardBE); end
    RdM = 9; Rs2E = 9; RegWriteM = 0; #1;
    n_checks++; if (ForwardBE !== 2'b00) begin n_fail++; $display("FAIL fwd_nowrite got %b want 00", ForwardBE); end
  endtask

  task automatic test_load_use();
    @(negedge clk); idle_inputs();
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; #1;
    n_checks++; if (ctl !== 7'b1100010) begin n_fail++; $display("FAIL lw_stall got %b want 1100010", ctl); end
    RdE = 0; Rs2D = 0; #1;
    n_checks++; if (ctl !== 7'b0) begin n_fail++; $display("FAIL lw_x0 got %b want 0000000", ctl); end
    ResultSrcE = 2'b00; RdE = 7; Rs1D = 7; #1;
    n_checks++; if (ctl !== 7'b0) begin n_fail++; $display("FAIL lw_notload got %b want 0000000", ctl); end
  endtask

  task automatic test_branch();
    @(negedge clk); idle_inputs(); PCSrcE = 1; #1;
    n_checks++; if (ctl !== 7'b0000110) begin n_fail++; $display("FAIL branch got %b want 0000110", ctl); end
    @(negedge clk); PCSrcE = 0; #1;
    n_checks++; if (ctl !== 7'b0) begin n_fail++; $display("FAIL branch_next got %b want 0000000", ctl); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); MemAccessM = 1; MemReadyM = 0; PCSrcE = (i == 1); #1;
      n_checks++; if (ctl !== HOLD) begin n_fail++; $display("FAIL mem_hold%0d got %b want %b", i, ctl, HOLD); end
    end
    @(negedge clk); MemReadyM = 1; PCSrcE = 1; #1;
    n_checks++; if (ctl !== 7'b0000110) begin n_fail++; $display("FAIL mem_release got %b want 0000110", ctl); end
    @(negedge clk); idle_inputs(); #1;
    n_checks++; if (ctl !== 7'b0) begin n_fail++; $display("FAIL mem_after got %b want 0000000", ctl); end
    n_checks++; if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL mem_no_timeout got %b want 0", mem_timeout); end
  endtask

  task automatic test_timeout();
    do_reset();
    @(negedge clk); MemAccessM = 1; MemReadyM = 0;
    for (int i = 1; i <= T + 2; i++) begin
      @(posedge clk); #1;
      n_checks++; if (mem_timeout !== (i >= T)) begin n_fail++; $display("FAIL timeout_edge%0d got %b want %b", i, mem_timeout, i >= T); end
    end
    n_checks++; if (ctl !== HOLD) begin n_fail++; $display("FAIL timeout_still_hold got %b want %b", ctl, HOLD); end
    @(negedge clk); MemReadyM = 1; @(posedge clk); #1;
    n_checks++; if (mem_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got %b want 1", mem_timeout); end
    @(negedge clk); MemReadyM = 0; reset = 1; @(posedge clk); #1;
    n_checks++; if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_reset got %b want 0", mem_timeout); end
    @(negedge clk); reset = 0; #1;
    n_checks++; if (ctl !== HOLD) begin n_fail++; $display("FAIL reset_abort_wait got %b want %b", ctl, HOLD); end
    do_reset();
  endtask

  task automatic test_perf_counters();
    logic [31:0] es, ef;
`ifdef HAZARD_PERF_CNT_EN
    es = 2; ef = 1;
`else
    es = 0; ef = 0;
`endif
    do_reset();
    @(negedge clk); ResultSrcE = 2'b01; RdE = 4; Rs1D = 4;
    @(negedge clk); idle_inputs();
    @(negedge clk); ResultSrcE = 2'b01; RdE = 6; Rs2D = 6;
    @(negedge clk); idle_inputs(); PCSrcE = 1;
    @(negedge clk); idle_inputs(); #1;
    n_checks++; if (stall_cycles !== es) begin n_fail++; $display("FAIL perf_stall got %0d want %0d", stall_cycles, es); end
    n_checks++; if (flush_cycles !== ef) begin n_fail++; $display("FAIL perf_flush got %0d want %0d", flush_cycles, ef); end
  endtask

  task automatic test_random();
    bit waiting = 0, tmo = 0, lw, hold;
    int wc = 0;
    logic [31:0] ms = 0, mf = 0;
    logic [6:0] ectl;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 39) == 0);
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
      ResultSrcE = 2'($urandom_range(0, 3));
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemAccessM = ($urandom_range(0, 3) == 0);
      MemReadyM = ($urandom_range(0, 9) < 6);
      lw = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      PCSrcE = lw ? 1'b0 : ($urandom_range(0, 4) == 0);
      hold = waiting ? !MemReadyM : (MemAccessM && !MemReadyM);
      ectl = reset ? 7'b0 : hold ? HOLD : {lw, lw, 2'b00, PCSrcE, lw | PCSrcE, 1'b0};
      #1;
      n_checks++; if (ctl !== ectl) begin n_fail++; $display("FAIL rnd_ctl[%0d] got %b want %b", n, ctl, ectl); end
      n_checks++; if (ForwardAE !== fwd(Rs1E) || ForwardBE !== fwd(Rs2E)) begin n_fail++; $display("FAIL rnd_fwd[%0d] got %b/%b want %b/%b", n, ForwardAE, ForwardBE, fwd(Rs1E), fwd(Rs2E)); end
      n_checks++; if (mem_timeout !== tmo) begin n_fail++; $display("FAIL rnd_timeout[%0d] got %b want %b", n, mem_timeout, tmo); end
`ifdef HAZARD_PERF_CNT_EN
      n_checks++; if (stall_cycles !== ms || flush_cycles !== mf) begin n_fail++; $display("FAIL rnd_cnt[%0d] got %0d/%0d want %0d/%0d", n, stall_cycles, flush_cycles, ms, mf); end
`else
      n_checks++; if (stall_cycles !== 0 || flush_cycles !== 0) begin n_fail++; $display("FAIL rnd_cnt_off[%0d] got %0d/%0d want 0/0", n, stall_cycles, flush_cycles); end
`endif
      @(posedge clk);
      if (reset) begin
        waiting = 0; wc = 0; tmo = 0; ms = 0; mf = 0;
      end else begin
        if (ectl[6]) ms++;
        if (ectl[2]) mf++;
        if (waiting) begin
          if (MemReadyM) begin waiting = 0; wc = 0; end
          else if (wc < T) wc++;
        end else if (MemAccessM && !MemReadyM) begin
          waiting = 1; wc = 1;
        end
        if (wc == T) tmo = 1;
      end
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_perf_counters();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
